// File: rtl/cpu_pkg.sv
// Shared constants for the Simple RISC Machine control unit: one-hot state
// codes, opcode/op fields, ALU operation codes and the instruction-kind enum.
package cpu_pkg;

  // One-hot state codes
  localparam logic [6:0] S_WAIT      = 7'b0000001;
  localparam logic [6:0] S_DECODE    = 7'b0000010;
  localparam logic [6:0] S_GET_A     = 7'b0000100;
  localparam logic [6:0] S_GET_B     = 7'b0001000;
  localparam logic [6:0] S_EXEC      = 7'b0010000;
  localparam logic [6:0] S_WRITE_REG = 7'b0100000;
  localparam logic [6:0] S_WRITE_IMM = 7'b1000000;

  // Opcode / op fields
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [2:0] {
    K_UNDEF, K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN
  } kind_t;

endpackage

// File: rtl/cpu_ctrl_instr_dec.sv
// Combinational instruction decoder: splits the IR into fields, builds the
// immediate extensions and classifies the instruction.
import cpu_pkg::*;

module instr_dec (
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [1:0]  op,
  output logic [15:0] imm8_sx,
  output logic [15:0] imm5_zx,
  output kind_t       kind
);

  logic [2:0] opcode;

  assign opcode  = ir[15:13];
  assign op      = ir[12:11];
  assign rn      = ir[10:8];
  assign rd      = ir[7:5];
  assign sh      = ir[4:3];
  assign rm      = ir[2:0];
  assign imm8_sx = {{8{ir[7]}}, ir[7:0]};
  assign imm5_zx = {11'd0, ir[4:0]};

  // Map opcode/op to an instruction kind; unlisted combinations are no-ops
  always_comb begin
    kind = K_UNDEF;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOVI)      kind = K_MOVI;
      else if (op == OP_MOVR) kind = K_MOVR;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  kind = K_ADD;
        OP_CMP:  kind = K_CMP;
        OP_AND:  kind = K_AND;
        default: kind = K_MVN;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Control unit for the Simple RISC Machine: instruction register, decoder and
// a one-hot Moore FSM driving the datapath strobes and selects.
import cpu_pkg::*;

module cpu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] datapath_in
);

  logic [15:0] ir;
  logic [6:0]  state, state_nx;
  logic [2:0]  rn, rd, rm;
  logic [1:0]  sh, op;
  logic [15:0] imm8_sx, imm5_zx;
  kind_t       kind;

  instr_dec u_dec (
    .ir      (ir),
    .rn      (rn),
    .rd      (rd),
    .rm      (rm),
    .sh      (sh),
    .op      (op),
    .imm8_sx (imm8_sx),
    .imm5_zx (imm5_zx),
    .kind    (kind)
  );

  // IR captures a new word only while idle
  always_ff @(posedge clk) begin
    if (reset)                          ir <= 16'h0000;
    else if (state == S_WAIT && load)   ir <= in;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT;
    else       state <= state_nx;
  end

  // Next-state sequencing; DECODE reads the IR so a same-edge load is seen
  always_comb begin
    state_nx = S_WAIT;
    case (state)
      S_WAIT:   state_nx = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (kind)
          K_MOVI:                 state_nx = S_WRITE_IMM;
          K_MOVR, K_MVN:          state_nx = S_GET_B;
          K_ADD, K_CMP, K_AND:    state_nx = S_GET_A;
          default:                state_nx = S_WAIT;
        endcase
      end
      S_GET_A:  state_nx = S_GET_B;
      S_GET_B:  state_nx = S_EXEC;
      S_EXEC:   state_nx = (kind == K_CMP) ? S_WAIT : S_WRITE_REG;
      default:  state_nx = S_WAIT;
    endcase
  end

  // Moore output decode from state and IR only
  always_comb begin
    w           = (state == S_WAIT);
    readnum     = 3'd0;
    writenum    = 3'd0;
    write       = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    vsel        = 1'b0;
    ALUop       = ALU_ADD;
    shift       = 2'b00;
    datapath_in = imm5_zx;
    case (state)
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = sh;
        ALUop = op;
        loadc = 1'b1;
        // MOV reg passes B through the adder with A forced to zero
        if (kind == K_MOVR) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end
        // CMP only updates status flags
        if (kind == K_CMP) begin
          loads = 1'b1;
          loadc = 1'b0;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum    = rn;
        vsel        = 1'b1;
        write       = 1'b1;
        datapath_in = imm8_sx;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: expected per-cycle output vectors are
// queued when an instruction is launched and popped as each edge completes.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = 16'h0000;
  logic        load = 1'b0;
  logic        s = 1'b0;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, vsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  ALUop, shift;
  logic [15:0] datapath_in;

  int tests = 0;
  int fails = 0;
  logic [34:0] q[$];
  logic [34:0] exp_v;
  logic [34:0] obs;

  cpu_ctrl dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .vsel(vsel), .ALUop(ALUop), .shift(shift), .datapath_in(datapath_in)
  );

  always #5 clk = ~clk;

  assign obs = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                asel, bsel, vsel, ALUop, shift, datapath_in};

  // strb = {write, loada, loadb, loadc, loads, asel, bsel, vsel}
  function automatic logic [34:0] ov(input logic w_, input logic [2:0] rn_,
                                     input logic [2:0] wn_, input logic [7:0] strb,
                                     input logic [1:0] alu_, input logic [1:0] sh_,
                                     input logic [15:0] dp_);
    return {w_, rn_, wn_, strb, alu_, sh_, dp_};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if (obs !== ov(1, 0, 0, 8'h00, 0, 0, 16'h0000)) begin
      fails++; $display("FAIL reset_outputs got %h exp %h", obs, ov(1, 0, 0, 8'h00, 0, 0, 16'h0000));
    end
    tests++;
    if (dut.ir !== 16'h0000) begin
      fails++; $display("FAIL reset_ir got %h exp 0000", dut.ir);
    end
    for (int i = 0; i < 3; i++) q.push_back(ov(1, 0, 0, 8'h00, 0, 0, 16'h0000));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp_v = q.pop_front();
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL reset_idle[%0d] got %h exp %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_mov_imm();
    in = 16'hD0FD; load = 1'b1; s = 1'b1;
    q.push_back(ov(0, 0, 0, 8'h00, 0, 0, 16'h001D));
    q.push_back(ov(0, 0, 0, 8'b1000_0001, 0, 0, 16'hFFFD));
    q.push_back(ov(1, 0, 0, 8'h00, 0, 0, 16'h001D));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      exp_v = q.pop_front();
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL mov_imm[%0d] got %h exp %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_add();
    in = 16'hA148; load = 1'b1; s = 1'b1;
    q.push_back(ov(0, 0, 0, 8'h00, 0, 0, 16'h0008));
    q.push_back(ov(0, 1, 0, 8'b0100_0000, 0, 0, 16'h0008));
    q.push_back(ov(0, 0, 0, 8'b0010_0000, 0, 0, 16'h0008));
    q.push_back(ov(0, 0, 0, 8'b0001_0000, 2'b00, 2'b01, 16'h0008));
    q.push_back(ov(0, 0, 2, 8'b1000_0000, 0, 0, 16'h0008));
    q.push_back(ov(1, 0, 0, 8'h00, 0, 0, 16'h0008));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      exp_v = q.pop_front();
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL add[%0d] got %h exp %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_cmp();
    in = 16'hA902; load = 1'b1; s = 1'b1;
    q.push_back(ov(0, 0, 0, 8'h00, 0, 0, 16'h0002));
    q.push_back(ov(0, 1, 0, 8'b0100_0000, 0, 0, 16'h0002));
    q.push_back(ov(0, 2, 0, 8'b0010_0000, 0, 0, 16'h0002));
    q.push_back(ov(0, 0, 0, 8'b0000_1000, 2'b01, 0, 16'h0002));
    q.push_back(ov(1, 0, 0, 8'h00, 0, 0, 16'h0002));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      exp_v = q.pop_front();
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL cmp[%0d] got %h exp %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_mvn();
    in = 16'hB827; load = 1'b1; s = 1'b1;
    q.push_back(ov(0, 0, 0, 8'h00, 0, 0, 16'h0007));
    q.push_back(ov(0, 7, 0, 8'b0010_0000, 0, 0, 16'h0007));
    q.push_back(ov(0, 0, 0, 8'b0001_0000, 2'b11, 0, 16'h0007));
    q.push_back(ov(0, 0, 1, 8'b1000_0000, 0, 0, 16'h0007));
    q.push_back(ov(1, 0, 0, 8'h00, 0, 0, 16'h0007));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      exp_v = q.pop_front();
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL mvn[%0d] got %h exp %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_undef();
    in = 16'hE000; load = 1'b1; s = 1'b1;
    q.push_back(ov(0, 0, 0, 8'h00, 0, 0, 16'h0000));
    q.push_back(ov(1, 0, 0, 8'h00, 0, 0, 16'h0000));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      s = 1'b0;
      // load pulse while in DECODE must be ignored
      if (i == 0) begin in = 16'hA148; load = 1'b1; end
      else load = 1'b0;
      exp_v = q.pop_front();
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL undef[%0d] got %h exp %h", i, obs, exp_v);
      end
    end
    tests++;
    if (dut.ir !== 16'hE000) begin
      fails++; $display("FAIL undef_ir got %h exp e000", dut.ir);
    end
  endtask

  task automatic test_reset_mid();
    in = 16'hA148; load = 1'b1; s = 1'b1;
    q.push_back(ov(0, 0, 0, 8'h00, 0, 0, 16'h0008));
    q.push_back(ov(0, 1, 0, 8'b0100_0000, 0, 0, 16'h0008));
    q.push_back(ov(0, 0, 0, 8'b0010_0000, 0, 0, 16'h0008));
    q.push_back(ov(0, 0, 0, 8'b0001_0000, 2'b00, 2'b01, 16'h0008));
    for (int i = 0; i < 4; i++) q.push_back(ov(1, 0, 0, 8'h00, 0, 0, 16'h0000));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      reset = (i == 3);
      exp_v = q.pop_front();
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL reset_mid[%0d] got %h exp %h", i, obs, exp_v);
      end
    end
    tests++;
    if (dut.ir !== 16'h0000) begin
      fails++; $display("FAIL reset_mid_ir got %h exp 0000", dut.ir);
    end
  endtask

  task automatic test_back_to_back();
    // MOV R3,R5,LSR#1 with s held; a load attempt while busy must not stick
    in = 16'hC075; load = 1'b1; s = 1'b1;
    for (int r = 0; r < 2; r++) begin
      q.push_back(ov(0, 0, 0, 8'h00, 0, 0, 16'h0015));
      q.push_back(ov(0, 5, 0, 8'b0010_0000, 0, 0, 16'h0015));
      q.push_back(ov(0, 0, 0, 8'b0001_0100, 2'b00, 2'b10, 16'h0015));
      q.push_back(ov(0, 0, 3, 8'b1000_0000, 0, 0, 16'h0015));
      q.push_back(ov(1, 0, 0, 8'h00, 0, 0, 16'h0015));
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) in = 16'hD0FD;
      else if (i == 3) load = 1'b0;
      if (i == 5) s = 1'b0;
      exp_v = q.pop_front();
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL back_to_back[%0d] got %h exp %h", i, obs, exp_v);
      end
    end
    tests++;
    if (dut.ir !== 16'hC075) begin
      fails++; $display("FAIL back_to_back_ir got %h exp c075", dut.ir);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mvn();
    test_undef();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
